// File: rtl/imm_pkg.sv
// Shared definitions for the registered immediate extender: format selects,
// occupancy states and the combinational decode function.
package imm_pkg;

    localparam logic [2:0] IMM_I     = 3'b000;
    localparam logic [2:0] IMM_S     = 3'b001;
    localparam logic [2:0] IMM_B     = 3'b010;
    localparam logic [2:0] IMM_J     = 3'b011;
    localparam logic [2:0] IMM_U     = 3'b100;
    localparam logic [2:0] IMM_SHAMT = 3'b101;
    localparam logic [2:0] IMM_ZIMM  = 3'b110;
    localparam logic [2:0] IMM_NONE  = 3'b111;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_state_e;

    typedef struct packed {
        logic        illegal;
        logic [63:0] imm;
    } imm_dec_t;

    // The immediate is always built at 64 bits; callers with XLEN=32 keep the
    // low half, which is exactly the 32-bit sign/zero extension.
    function automatic imm_dec_t imm_decode(input logic [31:0] instr,
                                            input logic [2:0]  sel,
                                            input int unsigned xlen);
        imm_dec_t    r;
        logic [63:0] sx;
        r.illegal = 1'b0;
        r.imm     = '0;
        sx        = {64{instr[31]}};
        case (sel)
            IMM_I: r.imm = {sx[63:12], instr[31:20]};
            IMM_S: r.imm = {sx[63:12], instr[31:25], instr[11:7]};
            IMM_B: r.imm = {sx[63:12], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_J: r.imm = {sx[63:20], instr[19:12], instr[20], instr[30:21], 1'b0};
            IMM_U: r.imm = {sx[63:32], instr[31:12], 12'b0};
            IMM_SHAMT: begin
                if ((xlen == 32) && instr[25]) begin
                    r.illegal = 1'b1;
                    r.imm     = {59'b0, instr[24:20]};
                end else begin
                    r.imm     = {58'b0, instr[25:20]};
                end
            end
            IMM_ZIMM: r.imm = {59'b0, instr[19:15]};
            default:  r.imm = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/imm_skid_buf.sv
// Two-entry skid buffer: output register visible at the ports, skid register
// behind it, in_ready decoded purely from the registered occupancy state.
module imm_skid_buf
    import imm_pkg::*;
#(
    parameter int unsigned W = 38
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);

    occ_state_e   state_q, state_d;
    logic [W-1:0] or_q, or_d;
    logic [W-1:0] sk_q, sk_d;
    logic         accept;
    logic         consume;

    assign in_ready_o  = (state_q != OCC_TWO);
    assign out_valid_o = (state_q != OCC_EMPTY);
    assign out_data_o  = or_q;

    assign accept  = in_valid_i && in_ready_o;
    assign consume = out_valid_o && out_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= OCC_EMPTY;
            or_q    <= '0;
            sk_q    <= '0;
        end else begin
            state_q <= state_d;
            or_q    <= or_d;
            sk_q    <= sk_d;
        end
    end

    // Registers load only on an accept or an SK->OR move, so an X on the
    // input data while in_valid is low never reaches the state.
    always_comb begin
        state_d = state_q;
        or_d    = or_q;
        sk_d    = sk_q;
        case (state_q)
            OCC_EMPTY: begin
                if (accept) begin
                    or_d    = in_data_i;
                    state_d = OCC_ONE;
                end
            end
            OCC_ONE: begin
                if (accept && consume) begin
                    or_d    = in_data_i;
                end else if (accept) begin
                    sk_d    = in_data_i;
                    state_d = OCC_TWO;
                end else if (consume) begin
                    state_d = OCC_EMPTY;
                end
            end
            OCC_TWO: begin
                if (consume) begin
                    or_d    = sk_q;
                    state_d = OCC_ONE;
                end
            end
            default: begin
                state_d = OCC_EMPTY;
            end
        endcase
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate extender: combinational decode on the input side,
// then a two-entry skid buffer carrying {illegal, tag, imm}.
module imm_extend_pipe
    import imm_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [2:0]       imm_sel,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);

    localparam int unsigned W = XLEN + TAG_W + 1;

    imm_dec_t     dec;
    logic [W-1:0] in_data;
    logic [W-1:0] out_data;

    always_comb begin
        dec = imm_decode(instr, imm_sel, XLEN);
    end

    assign in_data = {dec.illegal, in_tag, dec.imm[XLEN-1:0]};

    generate
        if (XLEN < 64) begin : g_narrow
            logic unused_hi;
            assign unused_hi = ^dec.imm[63:XLEN];
        end
    endgenerate

    imm_skid_buf #(
        .W (W)
    ) u_skid (
        .clk_i       (clk),
        .rst_ni      (reset),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data)
    );

    assign imm         = out_data[XLEN-1:0];
    assign out_tag     = out_data[XLEN +: TAG_W];
    assign out_illegal = out_data[W-1];

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe: one XLEN=32 and one XLEN=64 instance.
module tb_imm_extend_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic [2:0]  imm_sel;
    logic [4:0]  in_tag;
    logic        out_ready;

    logic        iv32, ir32, ov32, ill32;
    logic [31:0] imm32;
    logic [4:0]  tag32;
    logic        iv64, ir64, ov64, ill64;
    logic [63:0] imm64;
    logic [4:0]  tag64;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    imm_extend_pipe #(.XLEN(32), .TAG_W(5)) dut32 (
        .clk(clk), .reset(reset), .in_valid(iv32), .in_ready(ir32),
        .instr(instr), .imm_sel(imm_sel), .in_tag(in_tag),
        .out_valid(ov32), .out_ready(out_ready), .imm(imm32),
        .out_tag(tag32), .out_illegal(ill32)
    );

    imm_extend_pipe #(.XLEN(64), .TAG_W(5)) dut64 (
        .clk(clk), .reset(reset), .in_valid(iv64), .in_ready(ir64),
        .instr(instr), .imm_sel(imm_sel), .in_tag(in_tag),
        .out_valid(ov64), .out_ready(out_ready), .imm(imm64),
        .out_tag(tag64), .out_illegal(ill64)
    );

    typedef struct {
        string       name;
        logic        is64;
        logic [2:0]  sel;
        logic [31:0] instr;
        logic [63:0] imm;
        logic        ill;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic drive(input logic [2:0] sel, input logic [31:0] ins, input logic [4:0] tag);
        imm_sel = sel;
        instr   = ins;
        in_tag  = tag;
    endtask

    task automatic idle_inputs();
        iv32    = 1'b0;
        iv64    = 1'b0;
        instr   = 'x;
        imm_sel = 'x;
        in_tag  = 'x;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        vecs.push_back('{"I_neg",      1'b0, 3'b000, 32'hFFF00093, 64'h00000000FFFFFFFF, 1'b0});
        vecs.push_back('{"I_pos",      1'b0, 3'b000, 32'h7FF00093, 64'h00000000000007FF, 1'b0});
        vecs.push_back('{"S_neg",      1'b0, 3'b001, 32'hFE000E00, 64'h00000000FFFFFFFC, 1'b0});
        vecs.push_back('{"B_8",        1'b0, 3'b010, 32'h00000400, 64'h0000000000000008, 1'b0});
        vecs.push_back('{"J_neg2",     1'b0, 3'b011, 32'hFFFFF06F, 64'h00000000FFFFFFFE, 1'b0});
        vecs.push_back('{"J_sign",     1'b0, 3'b011, 32'h80000000, 64'h00000000FFF00000, 1'b0});
        vecs.push_back('{"U32_neg",    1'b0, 3'b100, 32'h80000037, 64'h0000000080000000, 1'b0});
        vecs.push_back('{"U64_pos",    1'b1, 3'b100, 32'h12345037, 64'h0000000012345000, 1'b0});
        vecs.push_back('{"U64_neg",    1'b1, 3'b100, 32'h80000037, 64'hFFFFFFFF80000000, 1'b0});
        vecs.push_back('{"SHAMT32_ill",1'b0, 3'b101, 32'h02100000, 64'h0000000000000001, 1'b1});
        vecs.push_back('{"SHAMT64_ok", 1'b1, 3'b101, 32'h02100000, 64'h0000000000000021, 1'b0});
        vecs.push_back('{"SHAMT32_zx", 1'b0, 3'b101, 32'h81F00000, 64'h000000000000001F, 1'b0});
        vecs.push_back('{"ZIMM_zx",    1'b0, 3'b110, 32'h800F8000, 64'h000000000000001F, 1'b0});
        vecs.push_back('{"NONE",       1'b0, 3'b111, 32'hFFFFFFFF, 64'h0000000000000000, 1'b0});
        vecs.push_back('{"I64_neg",    1'b1, 3'b000, 32'hFFF00093, 64'hFFFFFFFFFFFFFFFF, 1'b0});
        vecs.push_back('{"B64_sign",   1'b1, 3'b010, 32'h80000000, 64'hFFFFFFFFFFFFF000, 1'b0});

        // Reset state
        reset     = 1'b0;
        out_ready = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        check("rst_in_ready",  {63'b0, ir32}, 64'd1);
        check("rst_out_valid", {63'b0, ov32}, 64'd0);
        check("rst_imm",       {32'b0, imm32}, 64'd0);
        check("rst_tag",       {59'b0, tag32}, 64'd0);
        check("rst_illegal",   {63'b0, ill32}, 64'd0);
        check("rst64_valid",   {63'b0, ov64}, 64'd0);
        reset = 1'b1;

        // Table-driven format checks, one item at a time with out_ready high
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            check({vecs[i].name, "_in_ready"}, {63'b0, vecs[i].is64 ? ir64 : ir32}, 64'd1);
            drive(vecs[i].sel, vecs[i].instr, 5'(i + 1));
            if (vecs[i].is64) iv64 = 1'b1;
            else              iv32 = 1'b1;
            @(negedge clk);
            idle_inputs();
            if (vecs[i].is64) begin
                check({vecs[i].name, "_valid"}, {63'b0, ov64}, 64'd1);
                check({vecs[i].name, "_imm"},   imm64, vecs[i].imm);
                check({vecs[i].name, "_ill"},   {63'b0, ill64}, {63'b0, vecs[i].ill});
                check({vecs[i].name, "_tag"},   {59'b0, tag64}, 64'(i + 1));
            end else begin
                check({vecs[i].name, "_valid"}, {63'b0, ov32}, 64'd1);
                check({vecs[i].name, "_imm"},   {32'b0, imm32}, vecs[i].imm);
                check({vecs[i].name, "_ill"},   {63'b0, ill32}, {63'b0, vecs[i].ill});
                check({vecs[i].name, "_tag"},   {59'b0, tag32}, 64'(i + 1));
            end
        end
        @(negedge clk);
        check("drained32_valid", {63'b0, ov32}, 64'd0);
        check("drained64_valid", {63'b0, ov64}, 64'd0);

        // Backpressure: fill both entries, tag 3 is held off
        out_ready = 1'b0;
        drive(3'b000, 32'hFFF00093, 5'd1);
        iv32 = 1'b1;
        @(negedge clk);
        check("bp1_in_ready", {63'b0, ir32}, 64'd1);
        check("bp1_tag",      {59'b0, tag32}, 64'd1);
        drive(3'b000, 32'h00100093, 5'd2);
        @(negedge clk);
        check("bp2_in_ready", {63'b0, ir32}, 64'd0);
        check("bp2_tag_hold", {59'b0, tag32}, 64'd1);
        drive(3'b000, 32'h00200093, 5'd3);
        @(negedge clk);
        check("bp3_in_ready", {63'b0, ir32}, 64'd0);
        check("bp3_valid",    {63'b0, ov32}, 64'd1);
        check("bp3_tag_hold", {59'b0, tag32}, 64'd1);
        check("bp3_imm_hold", {32'b0, imm32}, 64'h00000000FFFFFFFF);
        out_ready = 1'b1;
        @(negedge clk);
        check("rel_tag2",      {59'b0, tag32}, 64'd2);
        check("rel_imm2",      {32'b0, imm32}, 64'd2 - 64'd1);
        check("rel_in_ready",  {63'b0, ir32}, 64'd1);
        @(negedge clk);
        idle_inputs();
        check("rel_tag3",      {59'b0, tag32}, 64'd3);
        check("rel_imm3",      {32'b0, imm32}, 64'd2);
        @(negedge clk);
        check("rel_empty",     {63'b0, ov32}, 64'd0);

        // Asynchronous reset while full, then a clean first push
        out_ready = 1'b0;
        drive(3'b001, 32'hFE000E00, 5'd4);
        iv32 = 1'b1;
        @(negedge clk);
        drive(3'b001, 32'hFE000E00, 5'd5);
        @(negedge clk);
        check("stall_in_ready", {63'b0, ir32}, 64'd0);
        idle_inputs();
        #2;
        reset = 1'b0;
        #1;
        check("arst_valid",    {63'b0, ov32}, 64'd0);
        check("arst_in_ready", {63'b0, ir32}, 64'd1);
        check("arst_tag",      {59'b0, tag32}, 64'd0);
        check("arst_imm",      {32'b0, imm32}, 64'd0);
        @(negedge clk);
        reset     = 1'b1;
        out_ready = 1'b1;
        drive(3'b000, 32'h7FF00093, 5'd6);
        iv32 = 1'b1;
        @(negedge clk);
        idle_inputs();
        check("post_rst_valid", {63'b0, ov32}, 64'd1);
        check("post_rst_tag",   {59'b0, tag32}, 64'd6);
        check("post_rst_imm",   {32'b0, imm32}, 64'h00000000000007FF);
        @(negedge clk);
        check("post_rst_empty", {63'b0, ov32}, 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
